apb_master_arbiter: RTL and testbench

APB_MASTER_ARBITER -- requirements
Module: apb_master_arbiter

---
 rtl/apb_master_arbiter_if.sv | 25 ++
 rtl/apb_master_arbiter.sv | 91 +++++++++
 tb/tb_apb_master_arbiter.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/apb_master_arbiter_if.sv
// apb_master_arbiter_if: requester command/completion ports and APB master bus of apb_master_arbiter
interface apb_master_arbiter_if;
  logic       req0_valid, req0_write, req0_ready, req0_done, req0_err;
  logic [7:0] req0_addr, req0_wdata, req0_rdata;
  logic       req1_valid, req1_write, req1_ready, req1_done, req1_err;
  logic [7:0] req1_addr, req1_wdata, req1_rdata;
  logic       PSELx, PENABLE, PWRITE, PREADY;
  logic [7:0] PADDR, PWDATA, PRDATA;
  modport master (
    input  req0_valid, req0_write, req0_addr, req0_wdata,
    input  req1_valid, req1_write, req1_addr, req1_wdata,
    input  PREADY, PRDATA,
    output req0_ready, req0_done, req0_rdata, req0_err,
    output req1_ready, req1_done, req1_rdata, req1_err,
    output PSELx, PENABLE, PWRITE, PADDR, PWDATA
  );
  modport slave (
    output req0_valid, req0_write, req0_addr, req0_wdata,
    output req1_valid, req1_write, req1_addr, req1_wdata,
    output PREADY, PRDATA,
    input  req0_ready, req0_done, req0_rdata, req0_err,
    input  req1_ready, req1_done, req1_rdata, req1_err,
    input  PSELx, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface

// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: two-requester round-robin APB master.
// Define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES wait states with err=1.
module apb_master_arbiter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic PCLK,
  input logic PRESET,
  apb_master_arbiter_if.master bus
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t state;
  logic gnt, last, pick, to;
  // Contention goes to the requester not granted last; otherwise whichever is valid.
  assign pick = (bus.req0_valid && bus.req1_valid) ? ~last : bus.req1_valid;
  assign bus.req0_ready = !PRESET && state == IDLE && bus.req0_valid && !pick;
  assign bus.req1_ready = !PRESET && state == IDLE && bus.req1_valid && pick;
`ifdef APB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  logic err0, err1;
  assign to = !bus.PREADY && cnt == CW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge PCLK or posedge PRESET)
    if (PRESET) begin
      cnt <= '0;
      err0 <= 1'b0;
      err1 <= 1'b0;
    end else begin
      cnt <= state == SETUP ? '0 : (state == ACCESS && !bus.PREADY) ? cnt + 1'b1 : cnt;
      if (state == ACCESS && (bus.PREADY || to)) begin
        if (gnt) err1 <= to;
        else err0 <= to;
      end
    end
  assign bus.req0_err = err0;
  assign bus.req1_err = err1;
`else
  assign to = 1'b0;
  assign bus.req0_err = 1'b0;
  assign bus.req1_err = 1'b0;
`endif
  // The APB address/data registers double as the latched command.
  always_ff @(posedge PCLK or posedge PRESET)
    if (PRESET) begin
      state <= IDLE;
      gnt <= 1'b0;
      last <= 1'b1;
      bus.PSELx <= 1'b0;
      bus.PENABLE <= 1'b0;
      bus.PWRITE <= 1'b0;
      bus.PADDR <= '0;
      bus.PWDATA <= '0;
      bus.req0_done <= 1'b0;
      bus.req1_done <= 1'b0;
      bus.req0_rdata <= '0;
      bus.req1_rdata <= '0;
    end else begin
      bus.req0_done <= 1'b0;
      bus.req1_done <= 1'b0;
      case (state)
        IDLE: if (bus.req0_valid || bus.req1_valid) begin
          state <= SETUP;
          gnt <= pick;
          last <= pick;
          bus.PSELx <= 1'b1;
          bus.PWRITE <= pick ? bus.req1_write : bus.req0_write;
          bus.PADDR <= pick ? bus.req1_addr : bus.req0_addr;
          bus.PWDATA <= pick ? bus.req1_wdata : bus.req0_wdata;
        end
        SETUP: begin
          state <= ACCESS;
          bus.PENABLE <= 1'b1;
        end
        ACCESS: if (bus.PREADY || to) begin
          state <= IDLE;
          bus.PSELx <= 1'b0;
          bus.PENABLE <= 1'b0;
          bus.PWRITE <= 1'b0;
          bus.PADDR <= '0;
          bus.PWDATA <= '0;
          if (gnt) begin
            bus.req1_done <= 1'b1;
            if (to || !bus.PWRITE) bus.req1_rdata <= to ? '0 : bus.PRDATA;
          end else begin
            bus.req0_done <= 1'b1;
            if (to || !bus.PWRITE) bus.req0_rdata <= to ? '0 : bus.PRDATA;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb_apb_master_arbiter: directed self-checking bench for apb_master_arbiter
module tb_apb_master_arbiter;
  logic PCLK = 1'b0;
  logic PRESET;
  int tests = 0;
  int fails = 0;
  apb_master_arbiter_if bus();
  apb_master_arbiter #(.TIMEOUT_CYCLES(16)) dut (.PCLK(PCLK), .PRESET(PRESET), .bus(bus.master));
  always #5 PCLK = ~PCLK;

  task automatic tick;
    @(posedge PCLK);
    #2;
  endtask

  task automatic test_reset;
    PRESET = 1'b1;
    bus.req0_valid = 0; bus.req0_write = 0; bus.req0_addr = 0; bus.req0_wdata = 0;
    bus.req1_valid = 0; bus.req1_write = 0; bus.req1_addr = 0; bus.req1_wdata = 0;
    bus.PREADY = 0; bus.PRDATA = 0;
    #3;
    tests++; if (bus.PSELx !== 1'b0 || bus.PENABLE !== 1'b0) begin fails++; $display("FAIL rst_psel_pen got %b%b exp 00", bus.PSELx, bus.PENABLE); end
    tests++; if (bus.PADDR !== 8'h00 || bus.PWDATA !== 8'h00 || bus.PWRITE !== 1'b0) begin fails++; $display("FAIL rst_bus got %h %h %b exp 00 00 0", bus.PADDR, bus.PWDATA, bus.PWRITE); end
    tests++; if (bus.req0_rdata !== 8'h00 || bus.req1_rdata !== 8'h00) begin fails++; $display("FAIL rst_rdata got %h %h exp 00 00", bus.req0_rdata, bus.req1_rdata); end
    tests++; if (bus.req0_done !== 1'b0 || bus.req1_done !== 1'b0 || bus.req0_err !== 1'b0 || bus.req1_err !== 1'b0) begin fails++; $display("FAIL rst_done_err got %b%b%b%b exp 0000", bus.req0_done, bus.req1_done, bus.req0_err, bus.req1_err); end
    bus.req0_valid = 1; bus.req1_valid = 1;
    #1;
    tests++; if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin fails++; $display("FAIL rst_ready got %b%b exp 00", bus.req0_ready, bus.req1_ready); end
    bus.req0_valid = 0; bus.req1_valid = 0;
    tick;
    PRESET = 1'b0;
  endtask

  task automatic test_write;
    bus.req0_valid = 1; bus.req0_write = 1; bus.req0_addr = 8'h02; bus.req0_wdata = 8'h5A; bus.PREADY = 1;
    #1;
    tests++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin fails++; $display("FAIL wr_ready got %b%b exp 10", bus.req0_ready, bus.req1_ready); end
    tick;
    bus.req0_valid = 0; bus.req0_addr = 8'hEE; bus.req0_wdata = 8'h11; bus.req0_write = 0;
    tests++; if (bus.PSELx !== 1'b1 || bus.PENABLE !== 1'b0) begin fails++; $display("FAIL wr_setup got %b%b exp 10", bus.PSELx, bus.PENABLE); end
    tests++; if (bus.PADDR !== 8'h02 || bus.PWDATA !== 8'h5A || bus.PWRITE !== 1'b1) begin fails++; $display("FAIL wr_setup_bus got %h %h %b exp 02 5a 1", bus.PADDR, bus.PWDATA, bus.PWRITE); end
    tick;
    tests++; if (bus.PSELx !== 1'b1 || bus.PENABLE !== 1'b1) begin fails++; $display("FAIL wr_access got %b%b exp 11", bus.PSELx, bus.PENABLE); end
    tests++; if (bus.PADDR !== 8'h02 || bus.PWDATA !== 8'h5A || bus.req0_done !== 1'b0) begin fails++; $display("FAIL wr_access_bus got %h %h %b exp 02 5a 0", bus.PADDR, bus.PWDATA, bus.req0_done); end
    tick;
    tests++; if (bus.req0_done !== 1'b1 || bus.req1_done !== 1'b0 || bus.req0_err !== 1'b0) begin fails++; $display("FAIL wr_done got %b%b%b exp 100", bus.req0_done, bus.req1_done, bus.req0_err); end
    tests++; if (bus.PSELx !== 1'b0 || bus.PENABLE !== 1'b0 || bus.PADDR !== 8'h00 || bus.PWDATA !== 8'h00) begin fails++; $display("FAIL wr_idle got %b%b %h %h exp 00 00 00", bus.PSELx, bus.PENABLE, bus.PADDR, bus.PWDATA); end
    tests++; if (bus.req0_rdata !== 8'h00) begin fails++; $display("FAIL wr_rdata_kept got %h exp 00", bus.req0_rdata); end
    tick;
    tests++; if (bus.req0_done !== 1'b0 || bus.PSELx !== 1'b0) begin fails++; $display("FAIL wr_one_pulse got %b%b exp 00", bus.req0_done, bus.PSELx); end
  endtask

  task automatic test_round_robin;
    PRESET = 1'b1;
    tick;
    PRESET = 1'b0;
    bus.req0_valid = 1; bus.req1_valid = 1; bus.req0_write = 0; bus.req1_write = 0; bus.PREADY = 1;
    for (int i = 0; i < 4; i++) begin
      bus.PRDATA = 8'h10 + 8'(i);
      #1;
      tests++; if (bus.req0_ready !== (i % 2 == 0) || bus.req1_ready !== (i % 2 == 1)) begin fails++; $display("FAIL rr_grant%0d got %b%b exp %b%b", i, bus.req0_ready, bus.req1_ready, i % 2 == 0, i % 2 == 1); end
      tick;
      tick;
      tick;
      if (i % 2 == 0) begin
        tests++; if (bus.req0_done !== 1'b1 || bus.req1_done !== 1'b0 || bus.req0_rdata !== 8'h10 + 8'(i)) begin fails++; $display("FAIL rr_done%0d got %b%b %h exp 10 %h", i, bus.req0_done, bus.req1_done, bus.req0_rdata, 8'h10 + 8'(i)); end
      end else begin
        tests++; if (bus.req1_done !== 1'b1 || bus.req0_done !== 1'b0 || bus.req1_rdata !== 8'h10 + 8'(i)) begin fails++; $display("FAIL rr_done%0d got %b%b %h exp 01 %h", i, bus.req0_done, bus.req1_done, bus.req1_rdata, 8'h10 + 8'(i)); end
      end
    end
    bus.req0_valid = 0; bus.req1_valid = 0;
  endtask

  task automatic test_wait_states;
    bus.req1_valid = 1; bus.req1_write = 0; bus.req1_addr = 8'h04; bus.PREADY = 0; bus.PRDATA = 8'h00;
    #1;
    tests++; if (bus.req1_ready !== 1'b1 || bus.req0_ready !== 1'b0) begin fails++; $display("FAIL ws_ready got %b%b exp 01", bus.req0_ready, bus.req1_ready); end
    tick;
    bus.req1_valid = 0; bus.req1_addr = 8'h99;
    tests++; if (bus.PADDR !== 8'h04 || bus.PWRITE !== 1'b0) begin fails++; $display("FAIL ws_setup got %h %b exp 04 0", bus.PADDR, bus.PWRITE); end
    for (int c = 0; c < 3; c++) begin
      tick;
      tests++; if (bus.PENABLE !== 1'b1 || bus.PADDR !== 8'h04 || bus.req1_done !== 1'b0) begin fails++; $display("FAIL ws_wait%0d got %b %h %b exp 1 04 0", c, bus.PENABLE, bus.PADDR, bus.req1_done); end
    end
    bus.PREADY = 1; bus.PRDATA = 8'hC3;
    tick;
    tests++; if (bus.req1_done !== 1'b1 || bus.req1_rdata !== 8'hC3) begin fails++; $display("FAIL ws_done got %b %h exp 1 c3", bus.req1_done, bus.req1_rdata); end
    tests++; if (bus.req0_done !== 1'b0 || bus.req0_rdata !== 8'h12) begin fails++; $display("FAIL ws_other got %b %h exp 0 12", bus.req0_done, bus.req0_rdata); end
    tick;
    tests++; if (bus.req1_done !== 1'b0) begin fails++; $display("FAIL ws_pulse got %b exp 0", bus.req1_done); end
  endtask

  task automatic test_busy_drop;
    bus.req1_valid = 1; bus.req1_write = 1; bus.req1_addr = 8'h08; bus.req1_wdata = 8'h77; bus.PREADY = 1;
    tick;
    bus.req1_valid = 0; bus.req0_valid = 1; bus.req0_write = 1; bus.req0_addr = 8'h33;
    #1;
    tests++; if (bus.req0_ready !== 1'b0) begin fails++; $display("FAIL bd_ready got %b exp 0", bus.req0_ready); end
    tick;
    bus.req0_valid = 0;
    tick;
    tests++; if (bus.req1_done !== 1'b1 || bus.req1_rdata !== 8'hC3) begin fails++; $display("FAIL bd_done got %b %h exp 1 c3", bus.req1_done, bus.req1_rdata); end
    tick;
    tests++; if (bus.PSELx !== 1'b0) begin fails++; $display("FAIL bd_no_xfer got %b exp 0", bus.PSELx); end
    tick;
    tests++; if (bus.PSELx !== 1'b0 || bus.req0_done !== 1'b0) begin fails++; $display("FAIL bd_no_xfer2 got %b%b exp 00", bus.PSELx, bus.req0_done); end
  endtask

  task automatic test_reset_mid;
    bus.req1_valid = 1; bus.req1_write = 0; bus.req1_addr = 8'h0A; bus.PREADY = 0;
    tick;
    tick;
    tests++; if (bus.PENABLE !== 1'b1) begin fails++; $display("FAIL rm_access got %b exp 1", bus.PENABLE); end
    PRESET = 1'b1;
    #1;
    tests++; if (bus.PSELx !== 1'b0 || bus.PENABLE !== 1'b0) begin fails++; $display("FAIL rm_async got %b%b exp 00", bus.PSELx, bus.PENABLE); end
    tick;
    tests++; if (bus.req1_done !== 1'b0 || bus.req0_done !== 1'b0) begin fails++; $display("FAIL rm_no_done got %b%b exp 00", bus.req0_done, bus.req1_done); end
    PRESET = 1'b0;
    bus.req0_valid = 1; bus.req0_write = 0;
    #1;
    tests++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin fails++; $display("FAIL rm_regrant got %b%b exp 10", bus.req0_ready, bus.req1_ready); end
    tick;
    bus.req0_valid = 0; bus.req1_valid = 0; bus.PREADY = 1; bus.PRDATA = 8'hAA;
    tick;
    tick;
    tests++; if (bus.req0_done !== 1'b1 || bus.req0_rdata !== 8'hAA) begin fails++; $display("FAIL rm_after got %b %h exp 1 aa", bus.req0_done, bus.req0_rdata); end
  endtask

`ifdef APB_TIMEOUT_EN
  task automatic test_timeout;
    bus.req0_valid = 1; bus.req0_write = 0; bus.req0_addr = 8'h20; bus.PREADY = 0;
    tick;
    bus.req0_valid = 0;
    tick;
    for (int c = 1; c < 16; c++) begin
      tick;
      tests++; if (bus.PENABLE !== 1'b1 || bus.req0_done !== 1'b0) begin fails++; $display("FAIL to_wait%0d got %b%b exp 10", c, bus.PENABLE, bus.req0_done); end
    end
    tick;
    tests++; if (bus.req0_done !== 1'b1 || bus.req0_err !== 1'b1 || bus.req0_rdata !== 8'h00) begin fails++; $display("FAIL to_done got %b%b %h exp 11 00", bus.req0_done, bus.req0_err, bus.req0_rdata); end
    tests++; if (bus.PSELx !== 1'b0 || bus.req1_err !== 1'b0) begin fails++; $display("FAIL to_idle got %b%b exp 00", bus.PSELx, bus.req1_err); end
  endtask
`else
  task automatic test_no_timeout;
    bus.req0_valid = 1; bus.req0_write = 0; bus.req0_addr = 8'h20; bus.PREADY = 0;
    tick;
    bus.req0_valid = 0;
    for (int c = 0; c < 20; c++) tick;
    tests++; if (bus.PENABLE !== 1'b1 || bus.req0_done !== 1'b0 || bus.req0_err !== 1'b0) begin fails++; $display("FAIL nt_wait got %b%b%b exp 100", bus.PENABLE, bus.req0_done, bus.req0_err); end
    bus.PREADY = 1; bus.PRDATA = 8'h5C;
    tick;
    tests++; if (bus.req0_done !== 1'b1 || bus.req0_err !== 1'b0 || bus.req0_rdata !== 8'h5C) begin fails++; $display("FAIL nt_done got %b%b %h exp 10 5c", bus.req0_done, bus.req0_err, bus.req0_rdata); end
  endtask
`endif

  initial begin
    test_reset;
    test_write;
    test_round_robin;
    test_wait_states;
    test_busy_drop;
    test_reset_mid;
`ifdef APB_TIMEOUT_EN
    test_timeout;
`else
    test_no_timeout;
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
